// File: rtl/fse_pkg.sv
// Shared formats, widths and helper functions for the FSE filter and its LMS partner.
package fse_pkg;

  localparam int NBT_IN   = 8;
  localparam int NBF_IN   = 7;
  localparam int NBT_TAPS = 10;
  localparam int NBF_TAPS = 7;
  localparam int NBT_OUT  = 10;
  localparam int NBF_OUT  = 7;

  localparam int NBT_PROD = NBT_IN + NBT_TAPS;
  localparam int NBF_PROD = NBF_IN + NBF_TAPS;
  localparam int NBT_ERR  = NBT_OUT + 1;

  localparam int OUT_SAT_MAX = (2 ** (NBT_OUT - 1)) - 1;
  localparam int OUT_SAT_MIN = -(2 ** (NBT_OUT - 1));

  localparam logic signed [NBT_OUT-1:0] DEC_LEVEL = 10'sd91;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Sum of 2*NUM_TAPS real products needs clog2(2*NUM_TAPS) growth bits.
  function automatic int acc_width(input int unsigned num_taps);
    return NBT_PROD + clog2(2 * num_taps);
  endfunction

  function automatic int warmup_max(input int unsigned num_taps);
    return int'((num_taps + 1) / 2);
  endfunction

endpackage

// File: rtl/fse_sat_trunc.sv
// Signed fixed-point conversion S(NBT_A,NBF_A) -> S(NBT_B,NBF_B):
// drop fraction LSBs (floor), then clamp integer range.
module fse_sat_trunc #(
  parameter int NBT_A = 23,
  parameter int NBF_A = 14,
  parameter int NBT_B = 10,
  parameter int NBF_B = 7
) (
  input  logic signed [NBT_A-1:0] i_a,
  output logic signed [NBT_B-1:0] o_b
);

  localparam int SH = NBF_A - NBF_B;
  localparam int NW = NBT_A - SH;

  logic signed [NW-1:0] t;
  assign t = i_a[NBT_A-1:SH];

  if (SH > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^i_a[SH-1:0];
  end

  always_comb begin
    if ((t[NW-1:NBT_B-1] == '0) || (t[NW-1:NBT_B-1] == '1)) begin
      o_b = t[NBT_B-1:0];
    end else if (t[NW-1]) begin
      o_b = {1'b1, {(NBT_B-1){1'b0}}};
    end else begin
      o_b = {1'b0, {(NBT_B-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fse_filter.sv
// Complex fractionally spaced equalizer datapath with QPSK DD error and LMS strobes.
// Optional FSE_TAP_FREEZE_EN adds i_freeze, which blocks o_en_taps.
module fse_filter
  import fse_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 9
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_en_rx,
  input  logic                         i_valid,
  input  logic [NBT_IN-1:0]            i_data_I,
  input  logic [NBT_IN-1:0]            i_data_Q,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_I,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_taps_Q,
  output logic [NBT_OUT-1:0]           o_y_I,
  output logic [NBT_OUT-1:0]           o_y_Q,
  output logic                         o_y_valid,
  output logic [NBT_OUT-1:0]           o_err_I,
  output logic [NBT_OUT-1:0]           o_err_Q,
  output logic                         o_en_shtr,
  output logic                         o_save_shftrs,
  output logic                         o_en_taps
`ifdef FSE_TAP_FREEZE_EN
  ,
  input  logic                         i_freeze
`endif
);

  localparam int         ACC_W  = acc_width(NUM_TAPS);
  localparam logic [3:0] WU_MAX = 4'(warmup_max(NUM_TAPS));

  logic rst, accept, freeze;
  assign rst    = i_reset | ~i_en_rx;
  assign accept = i_valid & ~rst;
`ifdef FSE_TAP_FREEZE_EN
  assign freeze = i_freeze;
`else
  assign freeze = 1'b0;
`endif

  logic signed [NBT_IN-1:0]   win_i_q [NUM_TAPS], win_i_d [NUM_TAPS];
  logic signed [NBT_IN-1:0]   win_q_q [NUM_TAPS], win_q_d [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] h_i [NUM_TAPS], h_q [NUM_TAPS];
  logic signed [NBT_PROD-1:0] p_ii_q [NUM_TAPS], p_ii_d [NUM_TAPS];
  logic signed [NBT_PROD-1:0] p_qq_q [NUM_TAPS], p_qq_d [NUM_TAPS];
  logic signed [NBT_PROD-1:0] p_iq_q [NUM_TAPS], p_iq_d [NUM_TAPS];
  logic signed [NBT_PROD-1:0] p_qi_q [NUM_TAPS], p_qi_d [NUM_TAPS];
  logic signed [ACC_W-1:0]    sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic signed [NBT_OUT-1:0]  y_i, y_q, err_i_sat, err_q_sat;
  logic signed [NBT_OUT-1:0]  err_i_q, err_i_d, err_q_q, err_q_d;
  logic signed [NBT_ERR-1:0]  diff_i, diff_q;
  phase_e                     phase_q, phase_d;
  logic                       save_q, save_d, prod_vld_q, prod_vld_d;
  logic                       y_vld_q, y_vld_d, en_taps_q, en_taps_d;
  logic [3:0]                 wu_q, wu_d;

  always_comb begin
    win_i_d = win_i_q;
    win_q_d = win_q_q;
    phase_d = phase_q;
    save_d  = 1'b0;
    if (accept) begin
      win_i_d[0] = i_data_I;
      win_q_d[0] = i_data_Q;
      for (int unsigned k = 1; k < NUM_TAPS; k++) begin
        win_i_d[k] = win_i_q[k-1];
        win_q_d[k] = win_q_q[k-1];
      end
      phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
      save_d  = (phase_q == PH_ODD);
    end
  end

  // Taps are read live here, so a tap update lands on the next symbol's window.
  always_comb begin
    p_ii_d     = p_ii_q;
    p_qq_d     = p_qq_q;
    p_iq_d     = p_iq_q;
    p_qi_d     = p_qi_q;
    prod_vld_d = save_q;
    for (int unsigned m = 0; m < NUM_TAPS; m++) begin
      h_i[m] = i_taps_I[m*NBT_TAPS +: NBT_TAPS];
      h_q[m] = i_taps_Q[m*NBT_TAPS +: NBT_TAPS];
      if (save_q) begin
        p_ii_d[m] = NBT_PROD'(h_i[m]) * NBT_PROD'(win_i_q[m]);
        p_qq_d[m] = NBT_PROD'(h_q[m]) * NBT_PROD'(win_q_q[m]);
        p_iq_d[m] = NBT_PROD'(h_i[m]) * NBT_PROD'(win_q_q[m]);
        p_qi_d[m] = NBT_PROD'(h_q[m]) * NBT_PROD'(win_i_q[m]);
      end
    end
  end

  always_comb begin
    sum_i_d = sum_i_q;
    sum_q_d = sum_q_q;
    y_vld_d = prod_vld_q;
    if (prod_vld_q) begin
      sum_i_d = '0;
      sum_q_d = '0;
      for (int unsigned m = 0; m < NUM_TAPS; m++) begin
        sum_i_d = sum_i_d + ACC_W'(p_ii_q[m]) - ACC_W'(p_qq_q[m]);
        sum_q_d = sum_q_d + ACC_W'(p_iq_q[m]) + ACC_W'(p_qi_q[m]);
      end
    end
  end

  fse_sat_trunc #(.NBT_A(ACC_W), .NBF_A(NBF_PROD), .NBT_B(NBT_OUT), .NBF_B(NBF_OUT))
    u_sat_y_i (.i_a(sum_i_q), .o_b(y_i));
  fse_sat_trunc #(.NBT_A(ACC_W), .NBF_A(NBF_PROD), .NBT_B(NBT_OUT), .NBF_B(NBF_OUT))
    u_sat_y_q (.i_a(sum_q_q), .o_b(y_q));

  always_comb begin
    diff_i = y_i[NBT_OUT-1] ? NBT_ERR'(y_i) + NBT_ERR'(DEC_LEVEL)
                            : NBT_ERR'(y_i) - NBT_ERR'(DEC_LEVEL);
    diff_q = y_q[NBT_OUT-1] ? NBT_ERR'(y_q) + NBT_ERR'(DEC_LEVEL)
                            : NBT_ERR'(y_q) - NBT_ERR'(DEC_LEVEL);
  end

  fse_sat_trunc #(.NBT_A(NBT_ERR), .NBF_A(NBF_OUT), .NBT_B(NBT_OUT), .NBF_B(NBF_OUT))
    u_sat_e_i (.i_a(diff_i), .o_b(err_i_sat));
  fse_sat_trunc #(.NBT_A(NBT_ERR), .NBF_A(NBF_OUT), .NBT_B(NBT_OUT), .NBF_B(NBF_OUT))
    u_sat_e_q (.i_a(diff_q), .o_b(err_q_sat));

  // Warm-up is judged on the count before this symbol, so the first WU_MAX symbols never adapt.
  always_comb begin
    err_i_d   = err_i_q;
    err_q_d   = err_q_q;
    en_taps_d = 1'b0;
    wu_d      = wu_q;
    if (y_vld_q) begin
      err_i_d   = err_i_sat;
      err_q_d   = err_q_sat;
      en_taps_d = (wu_q == WU_MAX) & ~freeze;
      if (wu_q != WU_MAX) wu_d = wu_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        win_i_q[k] <= '0;
        win_q_q[k] <= '0;
        p_ii_q[k]  <= '0;
        p_qq_q[k]  <= '0;
        p_iq_q[k]  <= '0;
        p_qi_q[k]  <= '0;
      end
      phase_q    <= PH_EVEN;
      save_q     <= 1'b0;
      prod_vld_q <= 1'b0;
      y_vld_q    <= 1'b0;
      en_taps_q  <= 1'b0;
      sum_i_q    <= '0;
      sum_q_q    <= '0;
      err_i_q    <= '0;
      err_q_q    <= '0;
      wu_q       <= '0;
    end else begin
      win_i_q    <= win_i_d;
      win_q_q    <= win_q_d;
      p_ii_q     <= p_ii_d;
      p_qq_q     <= p_qq_d;
      p_iq_q     <= p_iq_d;
      p_qi_q     <= p_qi_d;
      phase_q    <= phase_d;
      save_q     <= save_d;
      prod_vld_q <= prod_vld_d;
      y_vld_q    <= y_vld_d;
      en_taps_q  <= en_taps_d;
      sum_i_q    <= sum_i_d;
      sum_q_q    <= sum_q_d;
      err_i_q    <= err_i_d;
      err_q_q    <= err_q_d;
      wu_q       <= wu_d;
    end
  end

  assign o_en_shtr     = accept;
  assign o_save_shftrs = save_q;
  assign o_y_I         = y_i;
  assign o_y_Q         = y_q;
  assign o_y_valid     = y_vld_q;
  assign o_err_I       = err_i_q;
  assign o_err_Q       = err_q_q;
  assign o_en_taps     = en_taps_q;

endmodule

// File: tb/tb_fse_filter.sv
// Self-checking bench for fse_filter: directed vector table, reset/enable sequences,
// randomized symbols against an arithmetic reference model.
module tb_fse_filter;
  import fse_pkg::*;

  localparam int NT = 9;
  localparam int WU = 5;

  logic             clk = 1'b0;
  logic             i_reset, i_en_rx, i_valid, freeze;
  logic [7:0]       i_data_I, i_data_Q;
  logic [NT*10-1:0] i_taps_I, i_taps_Q;
  logic [9:0]       o_y_I, o_y_Q, o_err_I, o_err_Q;
  logic             o_y_valid, o_en_shtr, o_save_shftrs, o_en_taps;

  always #5 clk = ~clk;

  fse_filter #(.NUM_TAPS(NT)) dut (
    .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_valid(i_valid),
    .i_data_I(i_data_I), .i_data_Q(i_data_Q), .i_taps_I(i_taps_I), .i_taps_Q(i_taps_Q),
    .o_y_I(o_y_I), .o_y_Q(o_y_Q), .o_y_valid(o_y_valid), .o_err_I(o_err_I),
    .o_err_Q(o_err_Q), .o_en_shtr(o_en_shtr), .o_save_shftrs(o_save_shftrs),
    .o_en_taps(o_en_taps)
`ifdef FSE_TAP_FREEZE_EN
    , .i_freeze(freeze)
`endif
  );

  typedef struct {
    int acc;
    int yi, yq, ei, eq;
    bit en;
  } sym_t;

  typedef struct {
    string name;
    bit    center;
    int    h_i, h_q, x_i, x_q;
    int    y_i, y_q, e_i, e_q;
  } vec_t;

  sym_t pend[$];
  int   edge_n = 0, n_checks = 0, n_errors = 0, en_cnt = 0;
  bit   mon_en = 1'b0;
  int   hi[NT], hq[NT], wi[NT], wq[NT];
  int   phase, sym_cnt;
  int   last_yi, last_yq, last_ei, last_eq;

  function automatic int sx10(input logic [9:0] v);
    int r;
    r = $signed(v);
    return r;
  endfunction

  function automatic int clamp(input int v);
    if (v > OUT_SAT_MAX) return OUT_SAT_MAX;
    if (v < OUT_SAT_MIN) return OUT_SAT_MIN;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < NT; k++) begin
      wi[k] = 0;
      wq[k] = 0;
    end
    phase   = 0;
    sym_cnt = 0;
  endtask

  task automatic set_taps();
    for (int m = 0; m < NT; m++) begin
      i_taps_I[m*10 +: 10] = hi[m][9:0];
      i_taps_Q[m*10 +: 10] = hq[m][9:0];
    end
  endtask

  // Reference: window of the last NT samples, complex dot product, floor to 7 fraction bits.
  task automatic model_accept(input int xi, input int xq);
    sym_t s;
    int   si, sq, d;
    for (int k = NT - 1; k > 0; k--) begin
      wi[k] = wi[k-1];
      wq[k] = wq[k-1];
    end
    wi[0] = xi;
    wq[0] = xq;
    if (phase == 1) begin
      si = 0;
      sq = 0;
      for (int m = 0; m < NT; m++) begin
        si += hi[m] * wi[m] - hq[m] * wq[m];
        sq += hi[m] * wq[m] + hq[m] * wi[m];
      end
      s.acc = edge_n + 1;
      s.yi  = clamp(si >>> 7);
      s.yq  = clamp(sq >>> 7);
      d     = (s.yi >= 0) ? 91 : -91;
      s.ei  = clamp(s.yi - d);
      d     = (s.yq >= 0) ? 91 : -91;
      s.eq  = clamp(s.yq - d);
      s.en  = (sym_cnt >= WU) && !freeze;
      sym_cnt++;
      pend.push_back(s);
    end
    phase ^= 1;
  endtask

  task automatic send(input int xi, input int xq, input int gap);
    i_valid  = 1'b1;
    i_data_I = xi[7:0];
    i_data_Q = xq[7:0];
    #2;
    chk("en_shtr", int'(o_en_shtr), int'(i_en_rx && !i_reset));
    if (i_en_rx && !i_reset) model_accept(xi, xq);
    step();
    i_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y_I"}, sx10(o_y_I), 0);
    chk({tag, "_y_Q"}, sx10(o_y_Q), 0);
    chk({tag, "_err_I"}, sx10(o_err_I), 0);
    chk({tag, "_err_Q"}, sx10(o_err_Q), 0);
    chk({tag, "_strobes"}, int'({o_y_valid, o_save_shftrs, o_en_taps}), 0);
  endtask

  always begin
    @(posedge clk);
    edge_n++;
    #2;
    if (mon_en) begin
      bit   es, ey, ee;
      sym_t sy, se;
      es = 0; ey = 0; ee = 0;
      foreach (pend[k]) begin
        if (pend[k].acc == edge_n) es = 1;
        if (pend[k].acc == edge_n - 2) begin ey = 1; sy = pend[k]; end
        if (pend[k].acc == edge_n - 3) begin ee = 1; se = pend[k]; end
      end
      chk("save_shftrs", int'(o_save_shftrs), int'(es));
      chk("y_valid", int'(o_y_valid), int'(ey));
      if (ey) begin
        chk("y_I", sx10(o_y_I), sy.yi);
        chk("y_Q", sx10(o_y_Q), sy.yq);
        last_yi = sx10(o_y_I);
        last_yq = sx10(o_y_Q);
      end
      chk("en_taps", int'(o_en_taps), int'(ee && se.en));
      if (o_en_taps) en_cnt++;
      if (ee) begin
        chk("err_I", sx10(o_err_I), se.ei);
        chk("err_Q", sx10(o_err_Q), se.eq);
        last_ei = sx10(o_err_I);
        last_eq = sx10(o_err_Q);
      end
      while (pend.size() > 0 && pend[0].acc <= edge_n - 3) void'(pend.pop_front());
    end
  end

  initial begin
    vec_t vecs[4];
    int   base;
    vecs[0] = '{"identity", 1'b1, 128, 0, 64, -64, 64, -64, -27, 27};
    vecs[1] = '{"sat_pos", 1'b0, 511, 0, 127, 0, 511, 0, 420, -91};
    vecs[2] = '{"sat_neg", 1'b0, 511, 0, -128, 0, -512, 0, -421, -91};
    vecs[3] = '{"complex", 1'b0, 64, 64, 32, 16, 72, 216, -19, 125};

    i_reset = 1'b1; i_en_rx = 1'b1; i_valid = 1'b0; freeze = 1'b0;
    i_data_I = '0; i_data_Q = '0; i_taps_I = '0; i_taps_Q = '0;
    for (int m = 0; m < NT; m++) begin hi[m] = 0; hq[m] = 0; end
    repeat (3) step();
    check_zero("reset");
    chk("reset_en_shtr", int'(o_en_shtr), 0);
    model_reset();
    i_reset = 1'b0;
    mon_en  = 1'b1;

    for (int v = 0; v < 4; v++) begin
      for (int m = 0; m < NT; m++) begin
        hi[m] = (vecs[v].center && m != 4) ? 0 : vecs[v].h_i;
        hq[m] = (vecs[v].center && m != 4) ? 0 : vecs[v].h_q;
      end
      set_taps();
      for (int s = 0; s < 10; s++) send(vecs[v].x_i, vecs[v].x_q, 1);
      repeat (5) step();
      chk({vecs[v].name, "_y_I"}, last_yi, vecs[v].y_i);
      chk({vecs[v].name, "_y_Q"}, last_yq, vecs[v].y_q);
      chk({vecs[v].name, "_err_I"}, last_ei, vecs[v].e_i);
      chk({vecs[v].name, "_err_Q"}, last_eq, vecs[v].e_q);
    end

    // Reset during the third symbol, then warm-up must hold off o_en_taps for five symbols.
    for (int pass = 0; pass < 2; pass++) begin
      i_reset = 1'b1; step(); model_reset(); i_reset = 1'b0;
      for (int s = 0; s < 4; s++) send(s * 9 - 20, 30 - s * 7, 1);
      if (pass == 0) begin
        send(17, -5, 0);
        i_reset = 1'b1;
        step();
        model_reset();
        check_zero("midreset");
        i_reset = 1'b0;
      end else begin
        send(17, -5, 0);
        i_en_rx  = 1'b0;
        i_valid  = 1'b1;
        i_data_I = 8'h33;
        #2;
        chk("enrx_low_en_shtr", int'(o_en_shtr), 0);
        step();
        model_reset();
        i_valid = 1'b0;
        check_zero("enrx_low");
        i_en_rx = 1'b1;
      end
      base = en_cnt;
      for (int s = 0; s < 10; s++) send(40 - s * 11, s * 13 - 60, 1);
      repeat (5) step();
      chk("warmup_no_en", en_cnt - base, 0);
      send(25, 25, 1);
      send(-25, 50, 1);
      repeat (5) step();
      chk("warmup_first_en", en_cnt - base, 1);
    end

`ifdef FSE_TAP_FREEZE_EN
    base   = en_cnt;
    freeze = 1'b1;
    for (int s = 0; s < 12; s++) send(s * 5 - 30, 20 - s * 3, 1);
    repeat (5) step();
    chk("freeze_no_en", en_cnt - base, 0);
    freeze = 1'b0;
    send(10, 10, 1);
    send(-10, 20, 1);
    repeat (5) step();
    chk("freeze_release_en", en_cnt - base, 1);
`endif

    for (int m = 0; m < NT; m++) begin
      hi[m] = int'($urandom_range(0, 1023)) - 512;
      hq[m] = int'($urandom_range(0, 1023)) - 512;
    end
    set_taps();
    for (int s = 0; s < 80; s++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(1, 3)));
    end
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
